// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES-CTR counter register.
package aes_pkg;

   // Index width that never collapses to zero bits.
   function automatic int unsigned vbits(input int unsigned value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

   parameter int unsigned NumSlicesCtr     = 8;
   parameter int unsigned SliceSizeCtr     = 16;
   parameter int unsigned SliceIdxWidth    = vbits(NumSlicesCtr);
   parameter int unsigned CtrTimeoutCycles = 24;

   // Pairwise Hamming distance >= 3, so a single flipped bit never lands on another valid state.
   typedef enum logic [4:0] {
      CtrIdle  = 5'b01110,
      CtrReq   = 5'b11000,
      CtrWait  = 5'b00101,
      CtrError = 5'b10011
   } aes_ctr_reg_e;

endpackage

// File: rtl/aes_ctr_reg_if.sv
// Link between the counter register and the slice-serial increment FSM.
// Signal suffixes are from the counter register's point of view.
interface aes_ctr_reg_if
   import aes_pkg::*;
#(
   parameter int unsigned SliceW = SliceSizeCtr,
   parameter int unsigned IdxW   = SliceIdxWidth
) ();

   logic              fsm_incr_o;
   logic              fsm_ready_i;
   logic [IdxW-1:0]   fsm_slice_idx_i;
   logic [SliceW-1:0] fsm_slice_o;
   logic [SliceW-1:0] fsm_slice_i;
   logic              fsm_we_i;
   logic              fsm_alert_i;

   // Counter register side: issues the increment strobe and serves slices.
   modport master (
      output fsm_incr_o,
      output fsm_slice_o,
      input  fsm_ready_i,
      input  fsm_slice_idx_i,
      input  fsm_slice_i,
      input  fsm_we_i,
      input  fsm_alert_i
   );

   // Increment FSM side.
   modport slave (
      input  fsm_incr_o,
      input  fsm_slice_o,
      output fsm_ready_i,
      output fsm_slice_idx_i,
      output fsm_slice_i,
      output fsm_we_i,
      output fsm_alert_i
   );

endinterface

// File: rtl/aes_ctr_reg_wdog.sv
// Saturating watchdog for the WAIT phase of the counter increment.
module aes_ctr_reg_wdog #(
   parameter int unsigned TimeoutCycles = 24
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned     CntW    = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

   logic [CntW-1:0] cnt_q;

   // Count enabled cycles, holding at the limit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != CntMax)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // High during the enabled cycle that brings the count up to TimeoutCycles.
   assign expired_o = en_i && (cnt_q >= CntLast);

endmodule

// File: rtl/aes_ctr_reg.sv
// 128-bit AES-CTR counter register with increment handshake, slice port to the
// increment FSM, protocol checker, watchdog and sticky alert.
module aes_ctr_reg
   import aes_pkg::*;
#(
   parameter int unsigned  NumSlices     = NumSlicesCtr,
   parameter int unsigned  SliceW        = SliceSizeCtr,
   parameter int unsigned  TimeoutCycles = CtrTimeoutCycles,
   localparam int unsigned CtrW          = NumSlices * SliceW,
   localparam int unsigned IdxW          = vbits(NumSlices)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 iv_load_i,
   input  logic [CtrW-1:0]      iv_i,
   input  logic                 incr_req_i,
   output logic                 incr_ack_o,
   output logic [CtrW-1:0]      ctr_o,
   output logic [NumSlices-1:0] ctr_we_o,
   output logic                 alert_o,
   aes_ctr_reg_if.master        fsm_bus
);

   logic [NumSlices-1:0][SliceW-1:0] ctr_q;
   aes_ctr_reg_e                     state_q;
   logic                             fsm_incr_q;
   logic                             alert_q;

   logic [IdxW-1:0] slice_idx;
   logic [31:0]     idx_ext;
   logic            idx_oob;
   logic            state_bad;
   logic            wdog_expired;
   logic            fault;
   logic            load_en;
   logic            wr_en;

   assign slice_idx = fsm_bus.fsm_slice_idx_i;
   assign idx_ext   = 32'(slice_idx);
   assign idx_oob   = idx_ext >= NumSlices;
   assign state_bad = !(state_q inside {CtrIdle, CtrReq, CtrWait, CtrError});

   aes_ctr_reg_wdog #(
      .TimeoutCycles (TimeoutCycles)
   ) u_wdog (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (state_q != CtrWait),
      .en_i      (state_q == CtrWait),
      .expired_o (wdog_expired)
   );

   // Protocol checker: any violation this cycle sends the FSM to ERROR.
   always_comb begin
      fault = fsm_bus.fsm_alert_i
            | state_bad
            | (fsm_bus.fsm_we_i && ((state_q != CtrWait) || idx_oob))
            | (iv_load_i && (state_q != CtrIdle))
            | ((state_q == CtrWait) && !fsm_bus.fsm_ready_i && wdog_expired);
   end

   assign load_en = (state_q == CtrIdle) && iv_load_i && !fault;
   assign wr_en   = (state_q == CtrWait) && fsm_bus.fsm_we_i && !fault;

   // Per-slice write strobe mirrors the write performed at the coming edge.
   always_comb begin
      ctr_we_o = '0;
      if (wr_en) begin
         ctr_we_o[slice_idx] = 1'b1;
      end
   end

   // Counter storage: IV load in IDLE, single-slice writes in WAIT.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctr_q <= '0;
      end else if (load_en) begin
         ctr_q <= iv_i;
      end else if (wr_en) begin
         ctr_q[slice_idx] <= fsm_bus.fsm_slice_i;
      end
   end

   // Handshake FSM with registered increment strobe and sticky alert.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= CtrIdle;
         fsm_incr_q <= 1'b0;
         alert_q    <= 1'b0;
      end else if (fault) begin
         state_q    <= CtrError;
         fsm_incr_q <= 1'b0;
         alert_q    <= 1'b1;
      end else begin
         case (state_q)
            CtrIdle: begin
               // A same-cycle IV load wins; the held request is taken next cycle.
               if (!iv_load_i && incr_req_i && fsm_bus.fsm_ready_i) begin
                  state_q    <= CtrReq;
                  fsm_incr_q <= 1'b1;
               end
            end
            CtrReq: begin
               if (fsm_bus.fsm_ready_i) begin
                  state_q    <= CtrWait;
                  fsm_incr_q <= 1'b0;
               end
            end
            CtrWait: begin
               if (fsm_bus.fsm_ready_i) begin
                  state_q <= CtrIdle;
               end
            end
            CtrError: begin
               fsm_incr_q <= 1'b0;
               alert_q    <= 1'b1;
            end
            default: begin
               state_q    <= CtrError;
               fsm_incr_q <= 1'b0;
               alert_q    <= 1'b1;
            end
         endcase
      end
   end

   assign incr_ack_o          = (state_q == CtrWait) && fsm_bus.fsm_ready_i && !fault;
   assign ctr_o               = ctr_q;
   assign alert_o             = alert_q;
   assign fsm_bus.fsm_incr_o  = fsm_incr_q;
   assign fsm_bus.fsm_slice_o = idx_oob ? '0 : ctr_q[slice_idx];

endmodule

// File: tb/tb_aes_ctr_reg.sv
// Self-checking bench for aes_ctr_reg; the bench plays the increment FSM.
module tb_aes_ctr_reg;
   import aes_pkg::*;

   localparam int unsigned NS   = NumSlicesCtr;
   localparam int unsigned SW   = SliceSizeCtr;
   localparam int unsigned CW   = NS * SW;
   localparam int unsigned IdxW = SliceIdxWidth;
   localparam int          TO   = CtrTimeoutCycles;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          iv_load;
   logic [CW-1:0] iv;
   logic          incr_req;
   logic          incr_ack;
   logic [CW-1:0] ctr;
   logic [NS-1:0] ctr_we;
   logic          alert;

   int            checks;
   int            failures;
   logic [CW-1:0] model_ctr;

   aes_ctr_reg_if bus ();

   aes_ctr_reg #(
      .NumSlices     (NS),
      .SliceW        (SW),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .iv_load_i  (iv_load),
      .iv_i       (iv),
      .incr_req_i (incr_req),
      .incr_ack_o (incr_ack),
      .ctr_o      (ctr),
      .ctr_we_o   (ctr_we),
      .alert_o    (alert),
      .fsm_bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [SW-1:0] slice_of(input logic [CW-1:0] v, input int k);
      return v[k*SW +: SW];
   endfunction

   // Number of slices an increment of v rewrites (all eight on wrap-around).
   function automatic int n_changed(input logic [CW-1:0] v);
      logic [CW-1:0] nv;
      int            n;
      nv = v + 1'b1;
      n  = 0;
      for (int j = 0; j < NS; j++) if (slice_of(v, j) != slice_of(nv, j)) n++;
      return n;
   endfunction

   function automatic logic [CW-1:0] rand_ctr();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle_inputs();
      iv_load             = 1'b0;
      iv                  = '0;
      incr_req            = 1'b0;
      bus.fsm_ready_i     = 1'b1;
      bus.fsm_we_i        = 1'b0;
      bus.fsm_alert_i     = 1'b0;
      bus.fsm_slice_idx_i = '0;
      bus.fsm_slice_i     = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      model_ctr = '0;
   endtask

   task automatic load_iv(input logic [CW-1:0] v);
      iv_load = 1'b1;
      iv      = v;
      step();
      iv_load   = 1'b0;
      model_ctr = v;
   endtask

   // Acts as the FSM for one increment: handshake, one idle WAIT cycle, one write per
   // changed slice, 'stall' extra busy cycles, then ready. Reports ack cycle and deviations.
   task automatic run_incr(input int stall, output int ack_cyc, output int errs);
      logic [CW-1:0] old_v;
      logic [CW-1:0] new_v;
      logic [NS-1:0] exp_we;
      int            n;
      int            last;
      int            k;
      old_v   = model_ctr;
      new_v   = model_ctr + 1'b1;
      n       = n_changed(old_v);
      last    = n + 3 + stall;
      ack_cyc = -1;
      errs    = 0;
      for (int c = 0; c <= last + 2; c++) begin
         k                   = c - 3;
         incr_req            = (ack_cyc < 0);
         bus.fsm_ready_i     = (c <= 1) || (c >= last);
         bus.fsm_we_i        = (k >= 0) && (k < n);
         bus.fsm_slice_idx_i = bus.fsm_we_i ? IdxW'(k) : '0;
         bus.fsm_slice_i     = bus.fsm_we_i ? slice_of(new_v, k) : '0;
         @(negedge clk);
         if (bus.fsm_incr_o !== (c == 1)) errs++;
         exp_we = '0;
         if (bus.fsm_we_i) begin
            exp_we[k] = 1'b1;
            if (bus.fsm_slice_o !== slice_of(old_v, k)) errs++;
         end
         if (ctr_we !== exp_we) errs++;
         if (incr_ack === 1'b1) begin
            if (ack_cyc < 0) ack_cyc = c;
            else errs++;
         end else if (incr_ack !== 1'b0) begin
            errs++;
         end
         step();
      end
      idle_inputs();
      model_ctr = new_v;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n               = 1'b0;
      bus.fsm_slice_idx_i = IdxW'($urandom_range(0, NS - 1));
      #2;
      checks++; if (ctr !== '0) begin failures++; $display("FAIL reset_ctr: got %h want 0", ctr); end
      checks++; if (incr_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", incr_ack); end
      checks++; if (ctr_we !== '0) begin failures++; $display("FAIL reset_we: got %h want 0", ctr_we); end
      checks++; if (bus.fsm_incr_o !== 1'b0) begin failures++; $display("FAIL reset_incr: got %b want 0", bus.fsm_incr_o); end
      checks++; if (alert !== 1'b0) begin failures++; $display("FAIL reset_alert: got %b want 0", alert); end
      checks++; if (bus.fsm_slice_o !== '0) begin failures++; $display("FAIL reset_slice: got %h want 0", bus.fsm_slice_o); end
      do_reset();
   endtask

   task automatic test_single_slice();
      int ack_cyc;
      int errs;
      load_iv(128'h00FF);
      checks++; if (ctr !== 128'h00FF) begin failures++; $display("FAIL single_load: got %h want %h", ctr, 128'h00FF); end
      run_incr(0, ack_cyc, errs);
      checks++; if (ack_cyc != 4) begin failures++; $display("FAIL single_ack_cycle: got %0d want 4", ack_cyc); end
      checks++; if (errs != 0) begin failures++; $display("FAIL single_protocol: got %0d deviations want 0", errs); end
      checks++; if (ctr !== 128'h0100) begin failures++; $display("FAIL single_ctr: got %h want %h", ctr, 128'h0100); end
   endtask

   task automatic test_wrap();
      int ack_cyc;
      int errs;
      load_iv('1);
      run_incr(0, ack_cyc, errs);
      checks++; if (ack_cyc != NS + 3) begin failures++; $display("FAIL wrap_ack_cycle: got %0d want %0d", ack_cyc, NS + 3); end
      checks++; if (errs != 0) begin failures++; $display("FAIL wrap_protocol: got %0d deviations want 0", errs); end
      checks++; if (ctr !== '0) begin failures++; $display("FAIL wrap_ctr: got %h want 0", ctr); end
   endtask

   task automatic test_load_with_req();
      int ack_cyc;
      int errs;
      iv_load  = 1'b1;
      iv       = 128'd5;
      incr_req = 1'b1;
      @(negedge clk);
      checks++; if (bus.fsm_incr_o !== 1'b0) begin failures++; $display("FAIL loadreq_no_incr: got %b want 0", bus.fsm_incr_o); end
      step();
      iv_load   = 1'b0;
      model_ctr = 128'd5;
      checks++; if (ctr !== 128'd5) begin failures++; $display("FAIL loadreq_ctr5: got %h want 5", ctr); end
      run_incr(0, ack_cyc, errs);
      checks++; if (ack_cyc != 4) begin failures++; $display("FAIL loadreq_ack_cycle: got %0d want 4", ack_cyc); end
      checks++; if (errs != 0) begin failures++; $display("FAIL loadreq_protocol: got %0d deviations want 0", errs); end
      checks++; if (ctr !== 128'd6) begin failures++; $display("FAIL loadreq_ctr6: got %h want 6", ctr); end
   endtask

   task automatic test_random();
      logic [CW-1:0] v;
      int            n;
      int            stall;
      int            ack_cyc;
      int            errs;
      for (int it = 0; it < 6; it++) begin
         v = rand_ctr();
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) v[j*SW +: SW] = '1;
         n     = n_changed(v);
         stall = $urandom_range(0, TO - 2 - n);
         load_iv(v);
         run_incr(stall, ack_cyc, errs);
         checks++; if (ack_cyc != n + 3 + stall) begin failures++; $display("FAIL rand_ack_cycle[%0d]: got %0d want %0d", it, ack_cyc, n + 3 + stall); end
         checks++; if (errs != 0) begin failures++; $display("FAIL rand_protocol[%0d]: got %0d deviations want 0", it, errs); end
         checks++; if (ctr !== model_ctr) begin failures++; $display("FAIL rand_ctr[%0d]: got %h want %h", it, ctr, model_ctr); end
      end
   endtask

   // Ready arrives in the last WAIT cycle the watchdog allows.
   task automatic test_wdog_boundary();
      logic [CW-1:0] v;
      int            ack_cyc;
      int            errs;
      v         = rand_ctr();
      v[SW-1:0] = 16'h1234;
      load_iv(v);
      run_incr(TO - 3, ack_cyc, errs);
      checks++; if (ack_cyc != TO + 1) begin failures++; $display("FAIL wdog_edge_ack: got %0d want %0d", ack_cyc, TO + 1); end
      checks++; if (alert !== 1'b0) begin failures++; $display("FAIL wdog_edge_alert: got %b want 0", alert); end
      checks++; if (ctr !== model_ctr) begin failures++; $display("FAIL wdog_edge_ctr: got %h want %h", ctr, model_ctr); end
   endtask

   task automatic test_timeout();
      logic [CW-1:0] v;
      int            acks;
      int            incrs;
      do_reset();
      v = rand_ctr();
      load_iv(v);
      acks = 0;
      for (int c = 0; c < TO + 6; c++) begin
         incr_req        = 1'b1;
         bus.fsm_ready_i = (c <= 1) || (c >= TO + 2);
         @(negedge clk);
         if (incr_ack !== 1'b0) acks++;
         if (c == TO + 1) begin
            checks++; if (alert !== 1'b0) begin failures++; $display("FAIL timeout_early: got %b want 0", alert); end
         end
         if (c == TO + 2) begin
            checks++; if (alert !== 1'b1) begin failures++; $display("FAIL timeout_alert: got %b want 1", alert); end
         end
         step();
      end
      checks++; if (acks != 0) begin failures++; $display("FAIL timeout_no_ack: got %0d acks want 0", acks); end
      incrs = 0;
      for (int c = 0; c < 5; c++) begin
         bus.fsm_we_i    = 1'b1;
         bus.fsm_slice_i = SW'($urandom);
         @(negedge clk);
         if (bus.fsm_incr_o !== 1'b0 || incr_ack !== 1'b0 || ctr_we !== '0) incrs++;
         step();
      end
      idle_inputs();
      checks++; if (incrs != 0) begin failures++; $display("FAIL error_outputs_quiet: got %0d active cycles want 0", incrs); end
      checks++; if (alert !== 1'b1) begin failures++; $display("FAIL error_sticky: got %b want 1", alert); end
      checks++; if (ctr !== v) begin failures++; $display("FAIL error_ctr_frozen: got %h want %h", ctr, v); end
   endtask

   task automatic test_fault_we_idle();
      logic [CW-1:0] v;
      do_reset();
      v = rand_ctr();
      load_iv(v);
      bus.fsm_we_i        = 1'b1;
      bus.fsm_slice_idx_i = IdxW'($urandom_range(0, NS - 1));
      bus.fsm_slice_i     = ~slice_of(v, int'(bus.fsm_slice_idx_i));
      @(negedge clk);
      checks++; if (ctr_we !== '0) begin failures++; $display("FAIL we_idle_strobe: got %h want 0", ctr_we); end
      step();
      idle_inputs();
      @(negedge clk);
      checks++; if (alert !== 1'b1) begin failures++; $display("FAIL we_idle_alert: got %b want 1", alert); end
      checks++; if (ctr !== v) begin failures++; $display("FAIL we_idle_ctr: got %h want %h", ctr, v); end
      step();
   endtask

   task automatic test_fault_load_wait();
      logic [CW-1:0] v;
      do_reset();
      v = rand_ctr();
      load_iv(v);
      incr_req = 1'b1;
      step();
      step();
      bus.fsm_ready_i = 1'b0;
      iv_load         = 1'b1;
      iv              = ~v;
      @(negedge clk);
      checks++; if (alert !== 1'b0) begin failures++; $display("FAIL load_wait_early: got %b want 0", alert); end
      step();
      idle_inputs();
      @(negedge clk);
      checks++; if (alert !== 1'b1) begin failures++; $display("FAIL load_wait_alert: got %b want 1", alert); end
      checks++; if (ctr !== v) begin failures++; $display("FAIL load_wait_ctr: got %h want %h", ctr, v); end
      step();
   endtask

   task automatic test_fsm_alert();
      do_reset();
      bus.fsm_alert_i = 1'b1;
      step();
      bus.fsm_alert_i = 1'b0;
      @(negedge clk);
      checks++; if (alert !== 1'b1) begin failures++; $display("FAIL fsm_alert: got %b want 1", alert); end
      step();
   endtask

   task automatic test_reset_mid();
      logic [CW-1:0] v;
      int            ack_cyc;
      int            errs;
      do_reset();
      v         = rand_ctr();
      v[SW-1:0] = '1;
      load_iv(v);
      incr_req = 1'b1;
      step();
      step();
      bus.fsm_ready_i = 1'b0;
      step();
      bus.fsm_we_i        = 1'b1;
      bus.fsm_slice_idx_i = '0;
      bus.fsm_slice_i     = '0;
      #2;
      checks++; if (ctr_we !== NS'(1)) begin failures++; $display("FAIL mid_write_strobe: got %h want 1", ctr_we); end
      rst_n = 1'b0;
      #1;
      checks++; if (ctr !== '0) begin failures++; $display("FAIL mid_rst_ctr: got %h want 0", ctr); end
      checks++; if (ctr_we !== '0) begin failures++; $display("FAIL mid_rst_we: got %h want 0", ctr_we); end
      checks++; if (bus.fsm_incr_o !== 1'b0 || incr_ack !== 1'b0 || alert !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst_flags: got incr=%b ack=%b alert=%b want 000", bus.fsm_incr_o, incr_ack, alert);
      end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      model_ctr = '0;
      v = rand_ctr();
      load_iv(v);
      run_incr(0, ack_cyc, errs);
      checks++; if (ack_cyc != n_changed(v) + 3) begin failures++; $display("FAIL post_rst_ack: got %0d want %0d", ack_cyc, n_changed(v) + 3); end
      checks++; if (errs != 0) begin failures++; $display("FAIL post_rst_protocol: got %0d deviations want 0", errs); end
      checks++; if (ctr !== model_ctr) begin failures++; $display("FAIL post_rst_ctr: got %h want %h", ctr, model_ctr); end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      model_ctr = '0;
      rst_n     = 1'b0;
      test_reset();
      test_single_slice();
      test_wrap();
      test_load_with_req();
      test_random();
      test_wdog_boundary();
      test_timeout();
      test_fault_we_idle();
      test_fault_load_wait();
      test_fsm_alert();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
